// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: latches NUM_LINES edge/level sources behind a mask, arbitrates round-robin,
// and emits one line-id message per event toward the host channel, rate-limited by a hold-off counter.
module asp_irq_ctrl #(
  parameter int                   NUM_LINES         = 4,
  parameter int                   CSR_DATA_WIDTH    = 64,
  parameter int                   CSR_ADDR_WIDTH    = 3,
  parameter int                   HOLDOFF_WIDTH     = 16,
  parameter logic [NUM_LINES-1:0] DEFAULT_EDGE_MASK = 4'b0101,
  localparam int                  ID_W              = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_LINES-1:0]      irq_src,
  output logic                      irq_valid,
  output logic [ID_W-1:0]           irq_id,
  input  logic                      irq_ready,
  input  logic                      csr_write,
  input  logic                      csr_read,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
  input  logic [CSR_DATA_WIDTH-1:0] csr_writedata,
  output logic [CSR_DATA_WIDTH-1:0] csr_readdata,
  output logic                      csr_readdatavalid
);

  localparam logic [CSR_ADDR_WIDTH-1:0] A_PENDING  = CSR_ADDR_WIDTH'(0);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MASK     = CSR_ADDR_WIDTH'(1);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MODE     = CSR_ADDR_WIDTH'(2);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_HOLDOFF  = CSR_ADDR_WIDTH'(3);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_OVERFLOW = CSR_ADDR_WIDTH'(4);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_PARAMS   = CSR_ADDR_WIDTH'(5);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t                    r_state, w_next;
  logic [NUM_LINES-1:0]      r_pending, r_sent, r_overflow, r_mask, r_mode, r_src_q;
  logic [HOLDOFF_WIDTH-1:0]  r_holdoff, r_cnt;
  logic [ID_W-1:0]           r_rr, r_id;
  logic [CSR_DATA_WIDTH-1:0] r_readdata;
  logic                      r_rdvalid;

  logic [NUM_LINES-1:0]      w_eligible, w_edge, w_set, w_ovf_set, w_hs_vec;
  logic [NUM_LINES-1:0]      w_w1c_pend, w_w1c_ovf;
  logic [2*NUM_LINES-1:0]    w_dbl;
  logic [ID_W:0]             w_idx;
  logic [ID_W-1:0]           w_pick, w_rr_nxt;
  logic                      w_found, w_hs, w_load;
  logic [CSR_DATA_WIDTH-1:0] w_rd;

  // Source capture and pending/overflow/sent bookkeeping
  always_comb begin
    w_edge     = irq_src & ~r_src_q;
    w_set      = (r_mode & w_edge) | (~r_mode & irq_src);
    w_ovf_set  = r_mode & w_edge & r_pending;
    w_w1c_pend = (csr_write && csr_address == A_PENDING)  ? csr_writedata[NUM_LINES-1:0] : '0;
    w_w1c_ovf  = (csr_write && csr_address == A_OVERFLOW) ? csr_writedata[NUM_LINES-1:0] : '0;
    w_hs       = (r_state == S_SEND) && irq_ready;
    w_hs_vec   = w_hs ? (NUM_LINES'(1) << r_id) : '0;
    w_eligible = r_pending & ~r_sent & ~r_mask;
    w_rr_nxt   = (r_id == ID_W'(NUM_LINES - 1)) ? '0 : r_id + ID_W'(1);
  end

  // Round-robin pick: scan a doubled vector starting at the pointer so wrap needs no modulo
  always_comb begin
    w_dbl   = {w_eligible, w_eligible};
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      w_idx = {1'b0, r_rr} + (ID_W+1)'(i);
      if (!w_found && w_dbl[w_idx]) begin
        w_found = 1'b1;
        w_pick  = (w_idx >= (ID_W+1)'(NUM_LINES)) ? ID_W'(w_idx - (ID_W+1)'(NUM_LINES)) : ID_W'(w_idx);
      end
    end
  end

  // A HOLD cycle with an expired count arbitrates like IDLE, so HOLDOFF=0 costs exactly one gap cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found && r_cnt == '0) w_next = S_SEND;
      S_SEND:  if (irq_ready) w_next = S_HOLD;
      S_HOLD:  if (r_cnt == '0) w_next = w_found ? S_SEND : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_load = (r_state != S_SEND) && (w_next == S_SEND);
  end

  always_comb begin
    w_rd = '0;
    case (csr_address)
      A_PENDING:  w_rd[NUM_LINES-1:0]     = r_pending;
      A_MASK:     w_rd[NUM_LINES-1:0]     = r_mask;
      A_MODE:     w_rd[NUM_LINES-1:0]     = r_mode;
      A_HOLDOFF:  w_rd[HOLDOFF_WIDTH-1:0] = r_holdoff;
      A_OVERFLOW: w_rd[NUM_LINES-1:0]     = r_overflow;
      A_PARAMS:   w_rd[7:0]               = 8'(NUM_LINES);
      default:    w_rd                    = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_sent     <= '0;
      r_overflow <= '0;
      r_mask     <= '1;
      r_mode     <= DEFAULT_EDGE_MASK;
      r_holdoff  <= '0;
      r_cnt      <= '0;
      r_src_q    <= '0;
      r_rr       <= '0;
      r_id       <= '0;
      r_readdata <= '0;
      r_rdvalid  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_src_q    <= irq_src;
      r_pending  <= (r_pending & ~w_w1c_pend) | w_set;
      r_sent     <= (r_sent | w_hs_vec) & ~w_w1c_pend;
      r_overflow <= (r_overflow & ~w_w1c_ovf) | w_ovf_set;
      if (csr_write && csr_address == A_MASK)    r_mask    <= csr_writedata[NUM_LINES-1:0];
      if (csr_write && csr_address == A_MODE)    r_mode    <= csr_writedata[NUM_LINES-1:0];
      if (csr_write && csr_address == A_HOLDOFF) r_holdoff <= csr_writedata[HOLDOFF_WIDTH-1:0];
      if (w_load) r_id <= w_pick;
      if (w_hs) begin
        r_rr  <= w_rr_nxt;
        r_cnt <= r_holdoff;
      end else if (r_state == S_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - HOLDOFF_WIDTH'(1);
      end
      r_rdvalid  <= csr_read;
      r_readdata <= csr_read ? w_rd : '0;
    end
  end

  assign irq_valid         = (r_state == S_SEND);
  assign irq_id            = r_id;
  assign csr_readdata      = r_readdata;
  assign csr_readdatavalid = r_rdvalid;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Directed bench for asp_irq_ctrl: hand-computed expectations for reset state, delivery order,
// hold-off timing, level re-trigger, masking/overflow and a stalled handshake.
module tb_asp_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_src = '0;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic        irq_ready = 1'b0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [2:0]  csr_address = '0;
  logic [63:0] csr_writedata = '0;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  asp_irq_ctrl #(
    .NUM_LINES(4), .CSR_DATA_WIDTH(64), .CSR_ADDR_WIDTH(3), .HOLDOFF_WIDTH(16), .DEFAULT_EDGE_MASK(4'b0101)
  ) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ready(irq_ready), .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid)
  );

  always #5 clk = ~clk;

  // Message monitor: hs_* holds accepted messages (handshake lands on posedge cyc+1), rise_cyc valid rises
  int unsigned cyc = 0;
  int unsigned hs_cyc[$];
  logic [1:0]  hs_id[$];
  int unsigned rise_cyc[$];
  logic        prev_valid = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq_valid && irq_ready && !reset) begin
      hs_cyc.push_back(cyc);
      hs_id.push_back(irq_id);
    end
    if (irq_valid && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid = irq_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_cyc.delete();
    hs_id.delete();
    rise_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irq_src = '0;
    irq_ready = 1'b0;
    csr_write = 1'b0;
    csr_read = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [63:0] d);
    csr_write = 1'b1;
    csr_address = a;
    csr_writedata = d;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [63:0] d);
    csr_read = 1'b1;
    csr_address = a;
    tick();
    csr_read = 1'b0;
    check("rdvalid", 64'(csr_readdatavalid), 64'd1);
    d = csr_readdata;
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_src = v;
    tick();
    irq_src = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;

    // Reset state
    do_reset();
    check("rst_valid", 64'(irq_valid), 64'd0);
    check("rst_id", 64'(irq_id), 64'd0);
    check("rst_rdv", 64'(csr_readdatavalid), 64'd0);
    csr_rd(3'd0, d); check("rst_pending", d, 64'h0);
    csr_rd(3'd1, d); check("rst_mask", d, 64'hF);
    csr_rd(3'd2, d); check("rst_mode", d, 64'h5);
    csr_rd(3'd3, d); check("rst_holdoff", d, 64'h0);
    csr_rd(3'd5, d); check("params", d, 64'h4);
    csr_wr(3'd6, 64'hFFFF);
    csr_rd(3'd6, d); check("unused_addr", d, 64'h0);

    // 1: single edge pulse -> exactly one message, PENDING stays set; read+W1C returns pre-write value
    do_reset();
    csr_wr(3'd1, 64'h0);
    irq_ready = 1'b1;
    pulse(4'b0001);
    repeat (10) tick();
    check("t1_count", 64'(hs_id.size()), 64'd1);
    if (hs_id.size() >= 1) check("t1_id", 64'(hs_id[0]), 64'd0);
    csr_rd(3'd0, d); check("t1_pending", d, 64'h1);
    csr_read = 1'b1; csr_write = 1'b1; csr_address = 3'd0; csr_writedata = 64'h1;
    tick();
    csr_read = 1'b0; csr_write = 1'b0;
    check("t1_rw_same", csr_readdata, 64'h1);
    csr_rd(3'd0, d); check("t1_after_w1c", d, 64'h0);

    // 2: three lines at once -> 0,1,2 with one gap cycle each
    do_reset();
    csr_wr(3'd1, 64'h0);
    irq_ready = 1'b1;
    pulse(4'b0111);
    repeat (15) tick();
    check("t2_count", 64'(hs_id.size()), 64'd3);
    if (hs_id.size() >= 3) begin
      check("t2_id0", 64'(hs_id[0]), 64'd0);
      check("t2_id1", 64'(hs_id[1]), 64'd1);
      check("t2_id2", 64'(hs_id[2]), 64'd2);
      check("t2_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
      check("t2_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
    end

    // 3: HOLDOFF=10 -> second valid rises 11 cycles after the first handshake edge
    do_reset();
    csr_wr(3'd1, 64'h0);
    csr_wr(3'd3, 64'd10);
    irq_ready = 1'b1;
    pulse(4'b0101);
    repeat (30) tick();
    check("t3_count", 64'(hs_id.size()), 64'd2);
    if (hs_id.size() >= 2 && rise_cyc.size() >= 2) begin
      check("t3_id0", 64'(hs_id[0]), 64'd0);
      check("t3_id1", 64'(hs_id[1]), 64'd2);
      check("t3_holdoff", 64'(rise_cyc[1] - (hs_cyc[0] + 1)), 64'd11);
    end

    // 4: level line held high -> one message, W1C re-sets PENDING and yields a second message
    do_reset();
    csr_wr(3'd1, 64'h0);
    irq_ready = 1'b1;
    irq_src = 4'b0010;
    repeat (8) tick();
    check("t4_count1", 64'(hs_id.size()), 64'd1);
    csr_wr(3'd0, 64'h2);
    csr_rd(3'd0, d); check("t4_pending", d, 64'h2);
    repeat (8) tick();
    check("t4_count2", 64'(hs_id.size()), 64'd2);
    if (hs_id.size() >= 2) check("t4_id2", 64'(hs_id[1]), 64'd1);
    irq_src = '0;

    // 5: masked edge line fired twice -> no message, OVERFLOW set; unmask -> one message
    do_reset();
    irq_ready = 1'b1;
    pulse(4'b0100);
    tick(); tick();
    pulse(4'b0100);
    repeat (5) tick();
    check("t5_no_valid", 64'(rise_cyc.size()), 64'd0);
    csr_rd(3'd4, d); check("t5_overflow", d, 64'h4);
    csr_rd(3'd0, d); check("t5_pending", d, 64'h4);
    csr_wr(3'd1, 64'h0);
    repeat (6) tick();
    check("t5_count", 64'(hs_id.size()), 64'd1);
    if (hs_id.size() >= 1) check("t5_id", 64'(hs_id[0]), 64'd2);
    csr_wr(3'd4, 64'h4);
    csr_rd(3'd4, d); check("t5_ovf_clr", d, 64'h0);

    // 6: stalled handshake survives W1C and mask; reset drops valid next cycle
    do_reset();
    csr_wr(3'd1, 64'h0);
    irq_ready = 1'b0;
    pulse(4'b0100);
    for (int i = 0; i < 20 && !irq_valid; i++) tick();
    check("t6_valid_seen", 64'(irq_valid), 64'd1);
    csr_wr(3'd0, 64'h4);
    csr_wr(3'd1, 64'h4);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_hold_valid", 64'(irq_valid), 64'd1);
      check("t6_hold_id", 64'(irq_id), 64'd2);
    end
    reset = 1'b1;
    tick();
    check("t6_reset_valid", 64'(irq_valid), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
